pwm_generate: RTL and testbench
===============================

// Module: pwm_generate
// PURPOSE
//   Pulse-width transmitter: encodes an 8-bit code as a high-pulse width on pwm_out, once per fixed period.
//   Drives sensor-emulation and actuator outputs, and closes loopback tests against our width-measuring receiver.
//   Codes arrive via a valid/ready handshake and take effect only on a period boundary, so no pulse is ever torn.
// PARAMETERS
//   PERIOD_CYCLES  3_000_000  clk cycles per PWM period (>= 2)
//   SCALE          146        clk cycles of high time per code LSB
//   MIN_HIGH       0          fixed high cycles added to every pulse
//   CNT_W          24         counter/width register width; must hold PERIOD_CYCLES-1
// PORTS
//   clk           in   1      clock
//   reset         in   1      synchronous, active-high reset
//   enable        in   1      run generator; level-sensitive
//   value         in   8      code to transmit
//   value_valid   in   1      value is presented
//   value_ready   out  1      pending slot empty; transfer occurs when valid && ready
//   pwm_out       out  1      registered PWM output
//   period_start  out  1      one-cycle pulse on the first cycle of each period
//   busy          out  1      FSM not in IDLE
// BEHAVIOUR
//   Reset values:
//   - pwm_out=0, period_start=0, busy=0, value_ready=1.
//   - Pending slot empty; active width=MIN_HIGH (code 0); FSM=IDLE; counter=0.
//   Width arithmetic:
//   - width = MIN_HIGH + value*SCALE, computed at CNT_W bits, no overflow wrap.
//   - Clamp to PERIOD_CYCLES-1 so every period carries a falling edge.
//   - Computed and registered in the accept cycle, stored in the pending slot.
//   Handshake:
//   - value_ready = !pending_full.
//   - On accept, pending_full<=1 and value_ready falls the next cycle.
//   - value_valid while not ready is ignored; nothing is stored.
//   FSM states: IDLE, RUN.
//   - IDLE -> RUN on any cycle with enable=1. That edge is a boundary.
//   - RUN -> IDLE at the end of a period (counter==PERIOD_CYCLES-1) when enable=0 that cycle.
//   - Dropping enable mid-period never truncates the current pulse or period.
//   - IDLE holds pwm_out=0 and counter=0. The pending slot is still writable in IDLE.
//   Boundary (IDLE->RUN edge, or counter wrap while enable=1):
//   - counter<=0 and period_start<=1.
//   - If pending_full: active<=pending, pending_full<=0.
//   - pwm_out <= (new active width != 0).
//   Within RUN:
//   - counter increments each cycle.
//   - pwm_out<=0 on the edge where counter+1 == active width.
//   - The high time is therefore exactly active width cycles; width 0 gives no pulse that period.
//   Latency: a value accepted in cycle N applies at the first boundary at or after cycle N+1.
//   Simultaneous events:
//   - Accept in the same cycle as a boundary goes to pending and applies at the following boundary.
//   - A pending_full that was cleared on the boundary edge raises value_ready the next cycle.
//   Reset mid-period: pwm_out is 0 on the next edge; pending is discarded; active returns to code 0.
// STRUCTURE
//   pwm_pkg:
//   - typedef enum logic {IDLE, RUN} pwm_state_t.
//   - typedef logic [CNT_W-1:0] pwm_width_t.
//   - function clamp_width().
//   Sub-module pwm_width_calc (multiply-add-clamp, one register stage).
//   - Feeds the pending slot; the remainder stays flat in pwm_generate.
// TESTING  (PERIOD_CYCLES=20, SCALE=2, MIN_HIGH=1, CNT_W=8)
//   1. Reset, then enable=1 with no value:
//      -> period_start every 20 cycles; pwm_out high 1 cycle per period.
//   2. Accept value=3 mid-period:
//      -> current period unchanged; next period high exactly 7 cycles, low 13.
//   3. value=255:
//      -> width clamps to 19; pwm_out low exactly 1 cycle per period.
//   4. Accept 4; then hold valid with 5 before the boundary:
//      -> value_ready=0 and 5 not taken until the boundary.
//      -> Widths 9 then 11 in successive periods.
//   5. Drop enable at counter=3 with width 9:
//      -> pulse completes 9 high, period completes 20 cycles, then IDLE, busy=0, pwm_out=0.
//   6. Assert reset at counter=2 of a width-9 pulse:
//      -> pwm_out=0 the next cycle; after re-enable, width 1; the old pending is gone.
//   Loopback: drive the width-measuring receiver; its raw count tracks width-1 per period.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and width clamp helper for the PWM transmitter
package pwm_pkg;

    localparam int PWM_CNT_W  = 24;
    localparam int PWM_WIDE_W = 40;

    typedef enum logic {IDLE, RUN} pwm_state_t;
    typedef logic [PWM_CNT_W-1:0]  pwm_width_t;
    typedef logic [PWM_WIDE_W-1:0] pwm_wide_t;

    // Saturate rather than wrap so an oversized code still leaves a low cycle.
    function automatic pwm_wide_t clamp_width(input pwm_wide_t raw, input pwm_wide_t limit);
        return (raw > limit) ? limit : raw;
    endfunction

endpackage

// File: rtl/pwm_width_calc.sv
// rtl/pwm_width_calc.sv - code to pulse width: multiply-add-clamp into the pending slot register
module pwm_width_calc
    import pwm_pkg::*;
#(
    parameter int PERIOD_CYCLES = 3_000_000,
    parameter int SCALE         = 146,
    parameter int MIN_HIGH      = 0,
    parameter int CNT_W         = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [7:0]       value,
    output logic [CNT_W-1:0] width
);

    localparam pwm_wide_t LIMIT = pwm_wide_t'(PERIOD_CYCLES - 1);

    pwm_wide_t raw;

    // Arithmetic is done wide so the clamp sees the true product, never a wrapped one.
    assign raw = pwm_wide_t'(MIN_HIGH) + pwm_wide_t'(value) * pwm_wide_t'(SCALE);

    always_ff @(posedge clk) begin
        if (reset) begin
            width <= '0;
        end else if (load) begin
            width <= CNT_W'(clamp_width(raw, LIMIT));
        end
    end

endmodule

// File: rtl/pwm_generate.sv
// rtl/pwm_generate.sv - pulse-width transmitter, one code-encoded high pulse per fixed period
module pwm_generate
    import pwm_pkg::*;
#(
    parameter int PERIOD_CYCLES = 3_000_000,
    parameter int SCALE         = 146,
    parameter int MIN_HIGH      = 0,
    parameter int CNT_W         = PWM_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] value,
    input  logic       value_valid,
    output logic       value_ready,
    output logic       pwm_out,
    output logic       period_start,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ACTIVE_RESET =
        CNT_W'(clamp_width(pwm_wide_t'(MIN_HIGH), pwm_wide_t'(PERIOD_CYCLES - 1)));

    pwm_state_t       state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] next_active;
    logic             pending_full;
    logic             accept;
    logic             at_end;
    logic             boundary;

    assign value_ready = !pending_full;
    assign accept      = value_valid && value_ready;
    assign at_end      = (counter == LAST);
    assign boundary    = enable && ((state == IDLE) || at_end);
    assign next_active = pending_full ? pending : active;
    assign busy        = (state == RUN);

    pwm_width_calc #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .SCALE         (SCALE),
        .MIN_HIGH      (MIN_HIGH),
        .CNT_W         (CNT_W)
    ) u_width_calc (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .value (value),
        .width (pending)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            active       <= ACTIVE_RESET;
            pending_full <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            period_start <= 1'b0;

            // Accept and boundary-consume never coincide: accept needs an empty slot.
            if (accept) begin
                pending_full <= 1'b1;
            end else if (boundary && pending_full) begin
                pending_full <= 1'b0;
            end

            if (boundary) begin
                state        <= RUN;
                counter      <= '0;
                period_start <= 1'b1;
                active       <= next_active;
                pwm_out      <= (next_active != '0);
            end else if (state == RUN) begin
                if (at_end) begin
                    state   <= IDLE;
                    counter <= '0;
                    pwm_out <= 1'b0;
                end else begin
                    counter <= counter + ONE;
                    if (counter + ONE == active) begin
                        pwm_out <= 1'b0;
                    end
                end
            end else begin
                counter <= '0;
                pwm_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_generate.sv
// tb/tb_pwm_generate.sv - scoreboard bench: per-period pulse widths checked by a negedge monitor
module tb_pwm_generate;

    localparam int PERIOD = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] value = 8'd0;
    logic       value_valid = 1'b0;
    logic       value_ready;
    logic       pwm_out;
    logic       period_start;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int sb[$];

    bit in_period = 1'b0;
    bit fell = 1'b0;
    int len = 0;
    int lead = 0;
    int total = 0;

    pwm_generate #(
        .PERIOD_CYCLES (PERIOD),
        .SCALE         (2),
        .MIN_HIGH      (1),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .value        (value),
        .value_valid  (value_valid),
        .value_ready  (value_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic finalize_period();
        int exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_period actual_high=%0d required=none", total);
        end else begin
            exp = sb.pop_front();
            check("period_high_lead", lead, exp);
            check("period_high_total", total, exp);
            check("period_length", len, PERIOD);
        end
    endtask

    // Monitor: one record per completed period; periods cut short by reset are dropped.
    always @(negedge clk) begin
        if (reset) begin
            in_period = 1'b0;
        end else if (period_start) begin
            if (in_period) finalize_period();
            in_period = 1'b1;
            len   = 1;
            lead  = pwm_out ? 1 : 0;
            total = lead;
            fell  = !pwm_out;
        end else if (in_period) begin
            if (!busy) begin
                finalize_period();
                in_period = 1'b0;
            end else begin
                len++;
                if (pwm_out) begin
                    total++;
                    if (!fell) lead++;
                end else begin
                    fell = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ps(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 60);
        check(name, period_start, 1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 60);
    endtask

    initial begin
        int n;

        tick(3);
        check("reset_pwm_out", pwm_out, 0);
        check("reset_period_start", period_start, 0);
        check("reset_busy", busy, 0);
        check("reset_value_ready", value_ready, 1);
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // 1: no value loaded, width is MIN_HIGH
        sb.push_back(1);
        sb.push_back(1);
        enable = 1'b1;
        wait_ps("s1_first_start");
        check("s1_busy", busy, 1);
        wait_ps("s1_second_start");

        // 2: code 3 mid-period -> 1 + 3*2 = 7 next period
        tick(5);
        check("s2_ready_before", value_ready, 1);
        value = 8'd3;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        check("s2_ready_after_accept", value_ready, 0);
        sb.push_back(7);
        wait_ps("s2_start");
        check("s2_ready_after_boundary", value_ready, 1);

        // 3: code 255 clamps to 19
        tick(2);
        value = 8'd255;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        sb.push_back(19);
        wait_ps("s3_start");

        // 4: 4 accepted, 5 held back until the slot frees
        tick(3);
        value = 8'd4;
        value_valid = 1'b1;
        tick();
        value = 8'd5;
        check("s4_ready_full", value_ready, 0);
        tick(5);
        check("s4_ready_still_full", value_ready, 0);
        sb.push_back(9);
        sb.push_back(11);
        wait_ps("s4_first_start");
        check("s4_ready_reopened", value_ready, 1);
        tick();
        value_valid = 1'b0;
        check("s4_second_accepted", value_ready, 0);
        wait_ps("s4_second_start");

        // 5: width 9 period, enable dropped at counter 3
        tick();
        value = 8'd4;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        sb.push_back(9);
        wait_ps("s5_start");
        tick(3);
        enable = 1'b0;
        wait_idle(n);
        check("s5_cycles_to_idle", n + 3, PERIOD);
        check("s5_busy", busy, 0);
        check("s5_pwm_out", pwm_out, 0);
        tick(3);
        check("s5_idle_pwm_out", pwm_out, 0);
        check("s5_idle_period_start", period_start, 0);

        // 6: reset during a width-9 pulse with code 7 pending
        enable = 1'b1;
        tick();
        check("s6_start", period_start, 1);
        value = 8'd7;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        tick();
        check("s6_pwm_high_before_reset", pwm_out, 1);
        reset = 1'b1;
        enable = 1'b0;
        tick();
        check("s6_pwm_after_reset", pwm_out, 0);
        check("s6_busy_after_reset", busy, 0);
        check("s6_ready_after_reset", value_ready, 1);
        reset = 1'b0;
        sb.push_back(1);
        enable = 1'b1;
        wait_ps("s6_restart");
        enable = 1'b0;
        wait_idle(n);
        tick(2);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
